// File: rtl/morse_symbol_assembler.sv
// Morse letter assembler: synchronises two key switches, turns their toggles into
// dot/dash elements, and packs them into 1..MAX_LEN element letters behind a valid/ready slot.
module morse_symbol_assembler #(
  parameter int unsigned MAX_LEN     = 5,
  parameter int unsigned GAP_CYCLES  = 1000,
  parameter int unsigned SYNC_STAGES = 2,
  localparam int unsigned LEN_W      = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         sw,
  output logic [MAX_LEN-1:0] morse,
  output logic [LEN_W-1:0]   morse_len,
  output logic               morse_valid,
  input  logic               morse_ready,
  output logic               err
);

  localparam int unsigned GAP_W   = $clog2(GAP_CYCLES);
  localparam int unsigned PRIME_W = $clog2(SYNC_STAGES + 2);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_COMMIT,
    S_HOLD
  } state_t;

  state_t                         state_q, state_d;
  logic [MAX_LEN-1:0]             acc_q, acc_d;
  logic [LEN_W-1:0]               cnt_q, cnt_d;
  logic [GAP_W-1:0]               gap_q, gap_d;
  logic [SYNC_STAGES-1:0][1:0]    sync_q;
  logic [1:0]                     prev_q;
  logic [PRIME_W-1:0]             prime_q;
  logic                           err_d;
  logic                           load_c;

  logic                           primed_c;
  logic [1:0]                     ev_c;
  logic                           is_elem_c;
  logic                           collide_c;
  logic                           slot_free_c;
  logic [LEN_W-1:0]               shift_c;
  logic [MAX_LEN-1:0]             acc_app_c;
  logic [MAX_LEN-1:0]             acc_first_c;
  logic [LEN_W-1:0]               cnt_app_c;

  // Element decode; events are masked until the synchroniser has flushed its reset value
  assign primed_c    = (prime_q == PRIME_W'(SYNC_STAGES + 1));
  assign ev_c        = primed_c ? (sync_q[SYNC_STAGES-1] ^ prev_q) : 2'b00;
  assign is_elem_c   = (ev_c == 2'b01) || (ev_c == 2'b10);
  assign collide_c   = (ev_c == 2'b11);
  assign slot_free_c = !morse_valid || morse_ready;

  assign shift_c     = LEN_W'(MAX_LEN - 1) - cnt_q;
  assign acc_app_c   = acc_q | (MAX_LEN'(ev_c[1]) << shift_c);
  assign acc_first_c = MAX_LEN'(ev_c[1]) << (MAX_LEN - 1);
  assign cnt_app_c   = cnt_q + LEN_W'(1);

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    err_d   = 1'b0;
    load_c  = 1'b0;
    case (state_q)
      S_IDLE, S_COLLECT: begin
        err_d = collide_c;
        if (is_elem_c) begin
          acc_d   = acc_app_c;
          cnt_d   = cnt_app_c;
          gap_d   = '0;
          state_d = (cnt_app_c == LEN_W'(MAX_LEN)) ? S_COMMIT : S_COLLECT;
        end else if (state_q == S_COLLECT) begin
          if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
            state_d = S_COMMIT;
          end else begin
            gap_d = gap_q + GAP_W'(1);
          end
        end
      end
      S_COMMIT: begin
        err_d = collide_c;
        if (slot_free_c) begin
          load_c  = 1'b1;
          acc_d   = '0;
          cnt_d   = '0;
          gap_d   = '0;
          state_d = S_IDLE;
          // An element landing on the commit cycle opens the next letter
          if (is_elem_c) begin
            acc_d   = acc_first_c;
            cnt_d   = LEN_W'(1);
            state_d = (MAX_LEN == 1) ? S_COMMIT : S_COLLECT;
          end
        end else begin
          err_d   = is_elem_c || collide_c;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        err_d = is_elem_c || collide_c;
        if (slot_free_c) begin
          load_c  = 1'b1;
          acc_d   = '0;
          cnt_d   = '0;
          gap_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Synchroniser, priming counter and letter state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q  <= '0;
      prev_q  <= '0;
      prime_q <= '0;
      state_q <= S_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      gap_q   <= '0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], sw};
      prev_q  <= sync_q[SYNC_STAGES-1];
      if (!primed_c) begin
        prime_q <= prime_q + PRIME_W'(1);
      end
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
    end
  end

  // Output slot: stable while stalled, reloads on the transfer edge when a letter waits
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      morse       <= '0;
      morse_len   <= '0;
      morse_valid <= 1'b0;
      err         <= 1'b0;
    end else begin
      err <= err_d;
      if (load_c) begin
        morse       <= acc_q;
        morse_len   <= cnt_q;
        morse_valid <= 1'b1;
      end else if (morse_ready) begin
        morse_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_morse_symbol_assembler.sv
// Scoreboard bench for morse_symbol_assembler (MAX_LEN=5, GAP_CYCLES=8, SYNC_STAGES=2).
module tb_morse_symbol_assembler;

  localparam int unsigned MAX_LEN     = 5;
  localparam int unsigned GAP_CYCLES  = 8;
  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned LEN_W       = $clog2(MAX_LEN + 1);

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic [1:0]         sw = 2'b00;
  logic [MAX_LEN-1:0] morse;
  logic [LEN_W-1:0]   morse_len;
  logic               morse_valid;
  logic               morse_ready = 1'b0;
  logic               err;

  morse_symbol_assembler #(
    .MAX_LEN    (MAX_LEN),
    .GAP_CYCLES (GAP_CYCLES),
    .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .sw         (sw),
    .morse      (morse),
    .morse_len  (morse_len),
    .morse_valid(morse_valid),
    .morse_ready(morse_ready),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Edge counter: at the negedge after posedge k, cyc == k
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // at >= 0: required transfer edge; -1: don't care; -2: must follow previous transfer
  typedef struct {
    logic [MAX_LEN-1:0] m;
    logic [LEN_W-1:0]   l;
    int                 at;
  } exp_t;

  exp_t q[$];
  int total    = 0;
  int passed   = 0;
  int err_seen = 0;
  int exp_err  = 0;
  int last_pop = -10;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act == req) passed++;
    else $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, req, cyc);
  endtask

  task automatic push(input logic [MAX_LEN-1:0] m, input int l, input int at);
    exp_t e;
    e.m  = m;
    e.l  = LEN_W'(l);
    e.at = at;
    q.push_back(e);
  endtask

  // Monitor: pop and compare on every transfer, count err pulse cycles
  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset && err) err_seen++;
    if (reset && morse_valid && morse_ready) begin
      if (q.size() == 0) begin
        total++;
        $display("FAIL unexpected_letter: got morse=%b len=%0d, expected no letter", morse, morse_len);
      end else begin
        e = q.pop_front();
        check("morse", int'(morse), int'(e.m));
        check("morse_len", int'(morse_len), int'(e.l));
        if (e.at >= 0) check("valid_edge", cyc, e.at);
        else if (e.at == -2) check("back_to_back", cyc, last_pop + 1);
      end
      last_pop = cyc;
    end
  end

  task automatic tog(input int b);
    @(posedge clk);
    #1;
    sw[b] = ~sw[b];
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int r;
  int vc;

  initial begin
    // Switch held high through reset: no element, no err
    sw = 2'b11;
    idle(3);
    check("rst_morse", int'(morse), 0);
    check("rst_len", int'(morse_len), 0);
    check("rst_valid", int'(morse_valid), 0);
    check("rst_err", int'(err), 0);
    @(negedge clk);
    reset = 1'b1;
    vc = 0;
    repeat (30) begin
      @(negedge clk);
      if (morse_valid || err) vc++;
    end
    check("primed_quiet", vc, 0);

    // dot, dash, dot three cycles apart, gap close
    morse_ready = 1'b1;
    tog(0); idle(2); tog(1); idle(2); tog(0);
    r = cyc + 1 + SYNC_STAGES;
    push(5'b01000, 3, r + GAP_CYCLES + 1);
    vc = 0;
    repeat (20) begin
      @(negedge clk);
      if (morse_valid) vc++;
    end
    check("valid_cycles", vc, 1);

    // Full-length letter closes without gap wait; a later toggle starts a new letter
    tog(1); tog(0); tog(1); tog(1); tog(0);
    r = cyc + 1 + SYNC_STAGES;
    push(5'b10110, 5, r + 1);
    idle(1);
    tog(1);
    r = cyc + 1 + SYNC_STAGES;
    push(5'b10000, 1, r + GAP_CYCLES + 1);
    idle(20);

    // Stalled output: letter 2 enters HOLD, dot during HOLD is dropped with err
    morse_ready = 1'b0;
    tog(0); idle(2); tog(1);
    push(5'b01000, 2, -1);
    idle(12);
    tog(1);
    push(5'b10000, 1, -2);
    idle(14);
    tog(0);
    exp_err++;
    idle(6);
    check("hold_err_count", err_seen, exp_err);
    morse_ready = 1'b1;
    idle(5 + GAP_CYCLES);

    // Collision mid-letter leaves the letter untouched
    tog(1); idle(2); tog(0); idle(2);
    @(posedge clk);
    #1;
    sw = ~sw;
    exp_err++;
    push(5'b10000, 2, -1);
    idle(20);
    check("collide_err_count", err_seen, exp_err);

    // Async reset mid-letter with a stalled letter in the output slot
    morse_ready = 1'b0;
    tog(1);
    idle(14);
    check("stalled_valid", int'(morse_valid), 1);
    tog(0); tog(1);
    idle(3);
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    check("arst_morse", int'(morse), 0);
    check("arst_len", int'(morse_len), 0);
    check("arst_valid", int'(morse_valid), 0);
    #3 reset = 1'b1;
    morse_ready = 1'b1;
    idle(5);
    tog(0);
    r = cyc + 1 + SYNC_STAGES;
    push(5'b00000, 1, r + GAP_CYCLES + 1);

    // Drain with a bound
    for (int i = 0; i < 60 && q.size() != 0; i++) idle(1);
    idle(5);
    check("queue_drained", q.size(), 0);
    check("final_err_count", err_seen, exp_err);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/morse_symbol_assembler.md
# morse_symbol_assembler

Parametrised Morse letter assembler. It turns toggle events on two key switches into dot/dash elements and packs them into variable-length letters of 1..MAX_LEN elements. A letter is closed by an inter-letter gap timeout or by reaching MAX_LEN. Completed letters are presented on a valid/ready output register to the downstream character lookup stage, which may stall.

## Interface
- MAX_LEN, default 5: maximum elements per letter; legal range 1..16.
- GAP_CYCLES, default 1000: idle cycles after the last element that close a letter; must be ≥2.
- SYNC_STAGES, default 2: synchroniser depth on `sw`; must be ≥2.
- LEN_W, derived: $clog2(MAX_LEN+1).
- clk  input  1  clock; all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- sw  input  2  asynchronous key switches; a toggle of sw[0] is a dot (0), a toggle of sw[1] is a dash (1).
- morse  output  MAX_LEN  completed letter, first element in bit MAX_LEN-1, unused low bits 0.
- morse_len  output  LEN_W  number of valid elements in `morse`, 1..MAX_LEN.
- morse_valid  output  1  `morse`/`morse_len` hold a letter.
- morse_ready  input  1  downstream accepts; transfer occurs on an edge with valid && ready.
- err  output  1  one-cycle pulse on a dropped element (collision or HOLD drop).

## Operation
- Input path: each `sw` bit passes through SYNC_STAGES flops (reset 0). `prev` loads the synchronised value every cycle. An event is sync != prev.
- Priming: events are suppressed for the first SYNC_STAGES+1 cycles after reset release. A switch held high through reset therefore yields no element.
- Collision: both bits toggle in the same cycle → both discarded, err=1 for one cycle, no state change.
- Shift register `acc[MAX_LEN-1:0]` and element count `cnt`. Append writes the element to `acc[MAX_LEN-1-cnt]` and increments cnt.
- Gap counter `gap` clears on every append and increments each cycle in COLLECT without an element.
- States:
  - IDLE (cnt=0): an element appends, then goes to COLLECT (or to commit if MAX_LEN=1).
  - COLLECT: an element appends and clears gap. A commit fires when cnt reaches MAX_LEN on that append, or when gap reaches GAP_CYCLES-1 with no element. If an element and gap expiry coincide, the element wins: it is appended and the gap restarts.
  - Commit: if the output slot is free (!morse_valid, or morse_valid && morse_ready this cycle), load morse=acc, morse_len=cnt, morse_valid=1, clear acc/cnt/gap, and go to IDLE. Otherwise go to HOLD with acc/cnt frozen.
  - HOLD: any element is dropped with err=1. When the slot frees, load the output as in commit and go to IDLE.
- Output register: holds stable while valid && !ready. morse_valid clears after a transfer unless a new load happens on the same edge (back-to-back letters allowed).
- Reset (async, any state, mid-letter included): acc, cnt, gap, and state go to IDLE. Outputs go to morse=0, morse_len=0, morse_valid=0, err=0. A partial letter is discarded.

## Timing
- An `sw` change sampled at edge E0 is recorded as an element at edge E0+SYNC_STAGES.
- Full-length close: morse_valid rises 1 edge after the edge recording the MAX_LEN-th element (slot free).
- Gap close: morse_valid rises GAP_CYCLES+1 edges after the edge recording the last element, with no further elements and the slot free.
- HOLD → output load on the edge where valid && ready; the new letter is visible the following cycle with morse_valid still 1.
- err is registered and is high for exactly one cycle, on the cycle after the offending event is detected.
- Throughput: one element per cycle; one letter per cycle at the output.

## Test plan
Settings for all scenarios: MAX_LEN=5, GAP_CYCLES=8, SYNC_STAGES=2.
- Hold sw=2'b11 through reset and release → no element; morse_valid and err stay 0 for 30 cycles.
- Toggle sw[0], sw[1], sw[0], 3 cycles apart, with ready=1 → morse=5'b01000, morse_len=3. morse_valid is high for exactly one cycle, 9 edges after the third element is recorded.
- Five consecutive toggles dash, dot, dash, dash, dot → morse=5'b10110, morse_len=5. Valid rises 1 edge after the fifth element with no gap wait; a sixth toggle starts a new letter.
- Ready=0; send dot,dash (letter 1: 5'b01000/2), then after the gap send dash (letter 2: 5'b10000/1). Letter 2 enters HOLD; a dot during HOLD gives an err pulse and is dropped. Raise ready → letter 1 then letter 2 are delivered on consecutive cycles, with no trace of the dropped dot.
- Toggle both sw bits in the same cycle mid-letter → err for 1 cycle; the letter closes with its unchanged content and length.
- Record 2 elements, then pulse reset low mid-cycle → outputs go to 0 immediately. After release and priming, a single dot yields morse=5'b00000, morse_len=1.
